lock_sequencer: RTL and testbench



---
 rtl/lock_sequencer.sv | 162 ++++++++++++++++
 tb/tb_lock_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lock_sequencer.sv
// Laser/cavity lock sequencer: sweeps until the transmission monitor crosses threshold,
// settles, qualifies continuous lock, then holds LOCKED; bounded retries end in FAULT.
module lock_sequencer #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int QUAL_CYCLES   = 100000000,
  parameter int LOSS_CYCLES   = 16,
  parameter int MAX_RETRIES   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic [15:0] trans_in,
  input  logic [15:0] minval_in,
  output logic        sweep_on_out,
  output logic        sweep_hold_out,
  output logic        pid_on_out,
  output logic        pid_clr_out,
  output logic        locked_out,
  output logic        fault_out,
  output logic [2:0]  state_out,
  output logic [3:0]  retry_cnt_out
);

  localparam logic [2:0] ST_IDLE    = 3'b000;
  localparam logic [2:0] ST_SWEEP   = 3'b001;
  localparam logic [2:0] ST_CAPTURE = 3'b010;
  localparam logic [2:0] ST_QUALIFY = 3'b011;
  localparam logic [2:0] ST_LOCKED  = 3'b100;
  localparam logic [2:0] ST_FAULT   = 3'b101;

  // The loss counter only ever needs to reach LOSS_CYCLES-1 before it is cleared.
  localparam int LOSS_W = (LOSS_CYCLES < 2) ? 1 : $clog2(LOSS_CYCLES);

  // Output vector order: {sweep_on, sweep_hold, pid_on, pid_clr, locked, fault}
  localparam logic [5:0] OUT_IDLE  = 6'b000100;
  localparam logic [5:0] OUT_SWEEP = 6'b100100;
  localparam logic [5:0] OUT_TRACK = 6'b111000;
  localparam logic [5:0] OUT_LOCK  = 6'b111010;
  localparam logic [5:0] OUT_FAULT = 6'b000101;

  logic [2:0]        r_state;
  logic [26:0]       r_phase;
  logic [LOSS_W-1:0] r_loss;
  logic [3:0]        r_retry;
  logic [5:0]        r_out;

  logic              w_above;
  logic              w_tracking;
  logic              w_lost;
  logic [26:0]       w_phase_inc;
  logic [3:0]        w_retry_inc;
  logic [2:0]        w_state_nxt;
  logic [26:0]       w_phase_nxt;
  logic [LOSS_W-1:0] w_loss_nxt;
  logic [3:0]        w_retry_nxt;
  logic [5:0]        w_out_nxt;

  assign w_above     = $signed(trans_in) >= $signed(minval_in);
  assign w_tracking  = (r_state == ST_CAPTURE) || (r_state == ST_QUALIFY) ||
                       (r_state == ST_LOCKED);
  assign w_lost      = w_tracking && !w_above && (r_loss == LOSS_W'(LOSS_CYCLES - 1));
  assign w_phase_inc = (r_phase == '1) ? r_phase : r_phase + 27'd1;
  assign w_retry_inc = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_state_nxt = r_state;
    w_phase_nxt = w_phase_inc;
    w_loss_nxt  = w_above ? '0 : r_loss + 1'b1;
    w_retry_nxt = r_retry;

    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_SWEEP;
        w_phase_nxt = '0;
        w_loss_nxt  = '0;
      end
      ST_SWEEP: begin
        w_phase_nxt = '0;
        w_loss_nxt  = '0;
        if (w_above) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE, ST_QUALIFY: begin
        if (w_lost) begin
          w_retry_nxt = w_retry_inc;
          w_state_nxt = (w_retry_inc == 4'(MAX_RETRIES)) ? ST_FAULT : ST_SWEEP;
        end else if (r_state == ST_CAPTURE && r_phase == 27'(SETTLE_CYCLES - 1)) begin
          w_state_nxt = ST_QUALIFY;
          w_phase_nxt = '0;
        end else if (r_state == ST_QUALIFY && r_phase == 27'(QUAL_CYCLES - 1)) begin
          w_state_nxt = ST_LOCKED;
          w_phase_nxt = '0;
          w_retry_nxt = '0;
        end
      end
      ST_LOCKED: begin
        if (w_lost) w_state_nxt = ST_SWEEP;
      end
      ST_FAULT: begin
        w_phase_nxt = '0;
        w_loss_nxt  = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = '0;
        w_loss_nxt  = '0;
      end
    endcase

    // Counters restart whenever the sequencer leaves a tracking state.
    if (w_lost) begin
      w_phase_nxt = '0;
      w_loss_nxt  = '0;
    end

    if (!enable_in) begin
      w_state_nxt = ST_IDLE;
      w_phase_nxt = '0;
      w_loss_nxt  = '0;
      w_retry_nxt = '0;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as state_out.
  always_comb begin
    w_out_nxt = OUT_IDLE;
    case (w_state_nxt)
      ST_SWEEP:               w_out_nxt = OUT_SWEEP;
      ST_CAPTURE, ST_QUALIFY: w_out_nxt = OUT_TRACK;
      ST_LOCKED:              w_out_nxt = OUT_LOCK;
      ST_FAULT:               w_out_nxt = OUT_FAULT;
      default:                w_out_nxt = OUT_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_loss  <= '0;
      r_retry <= '0;
      r_out   <= OUT_IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_loss  <= w_loss_nxt;
      r_retry <= w_retry_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign sweep_on_out   = r_out[5];
  assign sweep_hold_out = r_out[4];
  assign pid_on_out     = r_out[3];
  assign pid_clr_out    = r_out[2];
  assign locked_out     = r_out[1];
  assign fault_out      = r_out[0];
  assign state_out      = r_state;
  assign retry_cnt_out  = r_retry;

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: directed lock scenarios plus randomized segments, all
// compared every cycle against a cycle-counting behavioural model of the sequencer.
module tb_lock_sequencer;

  localparam int SETTLE = 4;
  localparam int QUAL   = 20;
  localparam int LOSS   = 3;
  localparam int MAXR   = 2;

  localparam int S_IDLE    = 0;
  localparam int S_SWEEP   = 1;
  localparam int S_CAPTURE = 2;
  localparam int S_QUALIFY = 3;
  localparam int S_LOCKED  = 4;
  localparam int S_FAULT   = 5;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        enable_in;
  logic [15:0] trans_in;
  logic [15:0] minval_in;
  logic        sweep_on_out;
  logic        sweep_hold_out;
  logic        pid_on_out;
  logic        pid_clr_out;
  logic        locked_out;
  logic        fault_out;
  logic [2:0]  state_out;
  logic [3:0]  retry_cnt_out;

  lock_sequencer #(
    .SETTLE_CYCLES(SETTLE),
    .QUAL_CYCLES  (QUAL),
    .LOSS_CYCLES  (LOSS),
    .MAX_RETRIES  (MAXR)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .enable_in     (enable_in),
    .trans_in      (trans_in),
    .minval_in     (minval_in),
    .sweep_on_out  (sweep_on_out),
    .sweep_hold_out(sweep_hold_out),
    .pid_on_out    (pid_on_out),
    .pid_clr_out   (pid_clr_out),
    .locked_out    (locked_out),
    .fault_out     (fault_out),
    .state_out     (state_out),
    .retry_cnt_out (retry_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  int    n_total = 0;
  int    n_bad   = 0;
  string g_phase = "init";

  // Model: which phase we are in, how long we have been there, the current run of
  // below-threshold samples, and the failed attempts since the last lock.
  int m_state = S_IDLE;
  int m_time  = 0;
  int m_low   = 0;
  int m_retry = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s/%s got=%0h exp=%0h t=%0t", g_phase, tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] exp_outs(input int s);
    case (s)
      S_SWEEP:              return 6'b100100;
      S_CAPTURE, S_QUALIFY: return 6'b111000;
      S_LOCKED:             return 6'b111010;
      S_FAULT:              return 6'b000101;
      default:              return 6'b000100;
    endcase
  endfunction

  task automatic model_edge();
    bit above;
    above = $signed(trans_in) >= $signed(minval_in);
    if (rst_in) begin
      m_state = S_IDLE; m_time = 0; m_low = 0; m_retry = 0;
    end else if (!enable_in) begin
      m_state = S_IDLE; m_time = 0; m_low = 0; m_retry = 0;
    end else begin
      case (m_state)
        S_IDLE:  m_state = S_SWEEP;
        S_SWEEP: if (above) begin m_state = S_CAPTURE; m_time = 0; m_low = 0; end
        S_CAPTURE, S_QUALIFY, S_LOCKED: begin
          m_time++;
          m_low = above ? 0 : m_low + 1;
          if (m_low >= LOSS) begin
            m_low = 0; m_time = 0;
            if (m_state == S_LOCKED) m_state = S_SWEEP;
            else begin
              if (m_retry < 15) m_retry++;
              m_state = (m_retry == MAXR) ? S_FAULT : S_SWEEP;
            end
          end else if (m_state == S_CAPTURE && m_time == SETTLE) begin
            m_state = S_QUALIFY; m_time = 0;
          end else if (m_state == S_QUALIFY && m_time == QUAL) begin
            m_state = S_LOCKED; m_time = 0; m_retry = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_in);
    #1;
    check("state", 32'(state_out), 32'(m_state));
    check("retry", 32'(retry_cnt_out), 32'(m_retry));
    check("outs", 32'({sweep_on_out, sweep_hold_out, pid_on_out, pid_clr_out,
                       locked_out, fault_out}), 32'(exp_outs(m_state)));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Random sample that lands above (or below) the current threshold.
  function automatic logic [15:0] pick_trans(input bit want_above, input logic [15:0] mv);
    int lo;
    lo = int'($signed(mv)) + 32768;
    if (want_above || lo == 0) return 16'(int'($urandom_range(65535, lo)) - 32768);
    return 16'(int'($urandom_range(lo - 1, 0)) - 32768);
  endfunction

  initial begin
    rst_in    = 1'b1;
    enable_in = 1'b0;
    trans_in  = 16'd0;
    minval_in = 16'd16384;
    g_phase = "reset";
    run(2);
    check("rst_pid_clr", 32'(pid_clr_out), 32'd1);

    // Acquire from a dark cavity.
    g_phase = "acquire";
    rst_in = 1'b0; enable_in = 1'b1; trans_in = 16'd0;
    run(50);
    check("sweep_low", 32'(state_out), S_SWEEP);
    trans_in = 16'd20000;
    run(1);  check("capture", 32'(state_out), S_CAPTURE);
    run(4);  check("qualify", 32'(state_out), S_QUALIFY);
    run(19); check("still_qual", 32'(state_out), S_QUALIFY);
    run(1);  check("locked", 32'(state_out), S_LOCKED);
    check("locked_out", 32'(locked_out), 32'd1);

    // Short dropout tolerated, full dropout drops to sweep without a retry.
    g_phase = "locked_loss";
    trans_in = 16'd0; run(2); trans_in = 16'd20000; run(1);
    check("glitch", 32'(state_out), S_LOCKED);
    trans_in = 16'd0; run(2);
    check("pre_loss", 32'(state_out), S_LOCKED);
    run(1);
    check("lost", 32'(state_out), S_SWEEP);
    check("lost_retry", 32'(retry_cnt_out), 32'd0);

    // Two failed qualifications exhaust the retry budget.
    g_phase = "fault";
    trans_in = 16'd20000; run(10); trans_in = 16'd0; run(3);
    check("retry1", 32'(retry_cnt_out), 32'd1);
    check("retry1_st", 32'(state_out), S_SWEEP);
    trans_in = 16'd20000; run(10); trans_in = 16'd0; run(3);
    check("fault_st", 32'(state_out), S_FAULT);
    check("pid_off", 32'(pid_on_out), 32'd0);
    for (int i = 0; i < 100; i++) begin
      trans_in = 16'($urandom);
      step();
    end
    check("fault_hold", 32'(fault_out), 32'd1);
    enable_in = 1'b0; run(1);
    check("fault_exit", 32'(state_out), S_IDLE);

    // Reset in the middle of qualification restarts the full settle+qualify sequence.
    g_phase = "mid_reset";
    enable_in = 1'b1; trans_in = 16'd20000;
    run(16);
    check("in_qual", 32'(state_out), S_QUALIFY);
    rst_in = 1'b1; run(1); rst_in = 1'b0;
    check("reset_idle", 32'(state_out), S_IDLE);
    run(2);  check("recapture", 32'(state_out), S_CAPTURE);
    run(23); check("not_yet", 32'(state_out), S_QUALIFY);
    run(1);  check("relock", 32'(state_out), S_LOCKED);

    // Signed threshold boundary.
    g_phase = "boundary";
    trans_in = 16'd0; run(3);
    trans_in = 16'd16383; run(5);
    check("b16383", 32'(state_out), S_SWEEP);
    trans_in = 16'h8000; run(5);
    check("bneg", 32'(state_out), S_SWEEP);
    trans_in = 16'd16384; run(1);
    check("b16384", 32'(state_out), S_CAPTURE);

    // Disable on the very cycle loss would be declared.
    g_phase = "en_vs_loss";
    run(4); trans_in = 16'd0; run(3);
    check("pre_retry", 32'(retry_cnt_out), 32'd1);
    trans_in = 16'd20000; run(7);
    check("pre_qual", 32'(state_out), S_QUALIFY);
    trans_in = 16'd0; run(2);
    enable_in = 1'b0; run(1);
    check("en_idle", 32'(state_out), S_IDLE);
    check("en_retry", 32'(retry_cnt_out), 32'd0);

    // Randomized segments with varying dropout density and threshold.
    g_phase = "random";
    for (int seg = 0; seg < 15; seg++) begin
      int p_low;
      p_low = (seg % 3 == 0) ? 2 : ((seg % 3 == 1) ? 10 : 30);
      minval_in = (seg % 4 == 3) ? 16'($urandom) : 16'd16384;
      for (int c = 0; c < 200; c++) begin
        rst_in    = ($urandom_range(999, 0) < 5);
        enable_in = ($urandom_range(99, 0) >= 1);
        trans_in  = pick_trans($urandom_range(99, 0) >= p_low, minval_in);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
